// File: rtl/ds1302_bus_arbiter_if.sv
// ds1302_bus_arbiter_if: request, engine and DS1302 bus signals
// of the arbiter; master is the arbiter side.
interface ds1302_bus_arbiter_if;
  logic       rdReq;
  logic       wrReq;
  logic [7:0] wrAddr;
  logic [7:0] wrData;
  logic       wrReady;
  logic       wrDrop;
  logic       rdEn;
  logic       rdDone;
  logic       rdCe;
  logic       rdIoDir;
  logic       rdOut;
  logic       wrEn;
  logic [7:0] wrAddrOut;
  logic [7:0] wrDataOut;
  logic       wrDone;
  logic       wrCe;
  logic       wrIoDir;
  logic       wrOut;
  logic       ce;
  logic       dsOe;
  logic       dsOut;
  logic       busy;
  logic       timeoutErr;

  modport master (
    input  rdReq, wrReq, wrAddr, wrData,
    input  rdDone, rdCe, rdIoDir, rdOut,
    input  wrDone, wrCe, wrIoDir, wrOut,
    output wrReady, wrDrop, rdEn, wrEn,
    output wrAddrOut, wrDataOut,
    output ce, dsOe, dsOut, busy, timeoutErr
  );

  modport slave (
    output rdReq, wrReq, wrAddr, wrData,
    output rdDone, rdCe, rdIoDir, rdOut,
    output wrDone, wrCe, wrIoDir, wrOut,
    input  wrReady, wrDrop, rdEn, wrEn,
    input  wrAddrOut, wrDataOut,
    input  ce, dsOe, dsOut, busy, timeoutErr
  );
endinterface

// File: rtl/ds1302_bus_arbiter.sv
// ds1302_bus_arbiter: shares the DS1302 3-wire bus between the
// read and write engines. Option macro: DS1302_ARB_RETRY_EN.
module ds1302_bus_arbiter #(
  parameter int unsigned GAP_CYCLES     = 400,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst,
  ds1302_bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE, S_WAIT_WR, S_WAIT_RD, S_GAP
  } state_t;

  localparam logic [20:0] TO_LAST  = 21'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]  GAP_LAST = 9'(GAP_CYCLES - 1);

  state_t      r_state, w_next;
  logic [20:0] r_to_cnt;
  logic [8:0]  r_gap_cnt;
  logic        r_wr_pend, r_wr_ready, r_wr_drop;
  logic [7:0]  r_buf_addr, r_buf_data;
  logic [7:0]  r_addr_out, r_data_out;
  logic        r_wr_en, r_rd_en, r_rd_pend, r_to_err;

  logic w_in_wait, w_own_done, w_abort;
  logic w_start_wr, w_start_rd;

  assign w_in_wait  = (r_state == S_WAIT_WR) ||
                      (r_state == S_WAIT_RD);
  assign w_own_done = ((r_state == S_WAIT_WR) && bus.wrDone) ||
                      ((r_state == S_WAIT_RD) && bus.rdDone);
  assign w_abort    = w_in_wait && !w_own_done &&
                      (r_to_cnt == TO_LAST);
  assign w_start_wr = (r_state == S_IDLE) && r_wr_pend;
  assign w_start_rd = (r_state == S_IDLE) && !r_wr_pend &&
                      r_rd_pend;

`ifdef DS1302_ARB_RETRY_EN
  logic r_buf_retry, r_cur_retry;
  logic w_retry;
  assign w_retry = w_abort && (r_state == S_WAIT_WR) &&
                   !r_cur_retry;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next state: writes win, owner done or timeout ends a wait.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (r_wr_pend)      w_next = S_WAIT_WR;
        else if (r_rd_pend) w_next = S_WAIT_RD;
      end
      S_WAIT_WR, S_WAIT_RD: begin
        if (w_own_done || w_abort) w_next = S_GAP;
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Timeout counter (saturating, zero outside WAIT) and gap counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (!w_in_wait)          r_to_cnt <= '0;
      else if (r_to_cnt != '1) r_to_cnt <= r_to_cnt + 21'd1;
      if (r_state != S_GAP)    r_gap_cnt <= '0;
      else                     r_gap_cnt <= r_gap_cnt + 9'd1;
    end
  end

  // Read request coalescing and read engine start pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_pend <= 1'b0;
      r_rd_en   <= 1'b0;
    end else begin
      r_rd_en <= w_start_rd;
      if (w_start_rd) r_rd_pend <= 1'b0;
      if (bus.rdReq)  r_rd_pend <= 1'b1;
    end
  end

  // Write buffer, write engine launch, drop and abort pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_pend   <= 1'b0;
      r_wr_ready  <= 1'b1;
      r_wr_drop   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_to_err    <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
      r_addr_out  <= '0;
      r_data_out  <= '0;
`ifdef DS1302_ARB_RETRY_EN
      r_buf_retry <= 1'b0;
      r_cur_retry <= 1'b0;
`endif
    end else begin
      r_wr_en   <= w_start_wr;
      r_wr_drop <= 1'b0;
      if (w_start_wr) begin
        r_addr_out <= r_buf_addr;
        r_data_out <= r_buf_data;
        r_wr_pend  <= 1'b0;
        r_wr_ready <= 1'b1;
      end
      if (bus.wrReq) begin
        if (r_wr_ready) begin
          r_buf_addr <= bus.wrAddr;
          r_buf_data <= bus.wrData;
          r_wr_pend  <= 1'b1;
          r_wr_ready <= 1'b0;
        end else begin
          r_wr_drop <= 1'b1;
        end
      end
`ifdef DS1302_ARB_RETRY_EN
      r_to_err <= w_abort && !w_retry;
      if (w_start_wr) r_cur_retry <= r_buf_retry;
      if (bus.wrReq && r_wr_ready) r_buf_retry <= 1'b0;
      // The aborted write takes the buffer back ahead of newer work.
      if (w_retry) begin
        r_buf_addr  <= r_addr_out;
        r_buf_data  <= r_data_out;
        r_wr_pend   <= 1'b1;
        r_wr_ready  <= 1'b0;
        r_buf_retry <= 1'b1;
        if (r_wr_pend || bus.wrReq) r_wr_drop <= 1'b1;
      end
`else
      r_to_err <= w_abort;
`endif
    end
  end

  // Bus mux: only the registered owner reaches CE and the data line.
  always_comb begin
    bus.ce    = 1'b0;
    bus.dsOe  = 1'b0;
    bus.dsOut = 1'b0;
    unique case (r_state)
      S_WAIT_WR: begin
        bus.ce    = bus.wrCe;
        bus.dsOe  = bus.wrIoDir;
        bus.dsOut = bus.wrOut;
      end
      S_WAIT_RD: begin
        bus.ce    = bus.rdCe;
        bus.dsOe  = bus.rdIoDir;
        bus.dsOut = bus.rdOut;
      end
      default: ;
    endcase
  end

  assign bus.wrReady    = r_wr_ready;
  assign bus.wrDrop     = r_wr_drop;
  assign bus.rdEn       = r_rd_en;
  assign bus.wrEn       = r_wr_en;
  assign bus.wrAddrOut  = r_addr_out;
  assign bus.wrDataOut  = r_data_out;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.timeoutErr = r_to_err;
endmodule
